// File: rtl/shift_receiver.sv
// Purpose: serial-to-parallel receiver; assembles MSB-first frames of bitLength bits into a parallel word.
// Latency: word and dataValid update on the edge sampling the final bit (bitLength+1 edges from frameStart with continuous strobes).
// Backpressure: valid/ack handshake; a word completing while the previous one is unacknowledged is dropped and overrun latches.
module shift_receiver #(
    parameter int bitLength = 8
) (
    input  logic                 shiftClk,
    input  logic                 reset,
    input  logic                 frameStart,
    input  logic                 shiftEnabled,
    input  logic                 serialIn,
    input  logic                 dataAck,
    output logic [bitLength-1:0] dataBus,
    output logic                 dataValid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int cntWidth = $clog2(bitLength);
    localparam logic [cntWidth-1:0] lastBit = cntWidth'(bitLength - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state;
    state_t nextState;

    // Only bitLength-1 bits are ever held: the final bit goes straight from serialIn into the word.
    logic [bitLength-2:0] shiftReg;
    logic [cntWidth-1:0]  bitCount;
    logic                 wordDone;
    logic [bitLength-1:0] word;

    // Completion: a sampled strobe on the last bit, unless a coincident frameStart aborts the frame.
    always_comb begin
        word     = {shiftReg, serialIn};
        wordDone = (state == SHIFT) && !frameStart && shiftEnabled && (bitCount == lastBit);
    end

    // State register.
    always_ff @(posedge shiftClk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: frameStart enters (or restarts) SHIFT, completion returns to IDLE.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (frameStart) nextState = SHIFT;
            SHIFT:   if (frameStart) nextState = SHIFT;
                     else if (wordDone) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output logic: busy is a direct decode of the state register.
    always_comb begin
        busy = (state == SHIFT);
    end

    // Frame capture: clear on frameStart, shift one bit per strobe while in SHIFT.
    always_ff @(posedge shiftClk) begin
        if (reset) begin
            shiftReg <= '0;
            bitCount <= '0;
        end else if (frameStart) begin
            shiftReg <= '0;
            bitCount <= '0;
        end else if ((state == SHIFT) && shiftEnabled) begin
            shiftReg <= word[bitLength-2:0];
            if (bitCount == lastBit) begin
                bitCount <= '0;
            end else begin
                bitCount <= bitCount + cntWidth'(1);
            end
        end
    end

    // Delivery and handshake: a completion with a coincident ack replaces the word without a low cycle.
    always_ff @(posedge shiftClk) begin
        if (reset) begin
            dataBus   <= '0;
            dataValid <= 1'b0;
            overrun   <= 1'b0;
        end else if (wordDone) begin
            if (!dataValid || dataAck) begin
                dataBus   <= word;
                dataValid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (dataValid && dataAck) begin
            dataValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_receiver.sv
// Purpose: directed checks of shift_receiver framing, gapped strobes, handshake, overrun, abort and reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: dataAck driven from the vector table and hand sequences.
module tb_shift_receiver;

    logic       shiftClk = 1'b0;
    logic       reset = 1'b1;
    logic       frameStart = 1'b0;
    logic       shiftEnabled = 1'b0;
    logic       serialIn = 1'b0;
    logic       dataAck = 1'b0;
    logic [7:0] dataBus;
    logic       dataValid;
    logic       busy;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int riseCount = 0;
    logic prevValid = 1'b0;

    shift_receiver #(.bitLength(8)) dut (
        .shiftClk    (shiftClk),
        .reset       (reset),
        .frameStart  (frameStart),
        .shiftEnabled(shiftEnabled),
        .serialIn    (serialIn),
        .dataAck     (dataAck),
        .dataBus     (dataBus),
        .dataValid   (dataValid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 shiftClk = ~shiftClk;

    typedef struct {
        logic [7:0] word;
        int         gap;
        logic       strobeOnStart;
        logic       ackOnLast;
        logic       preValid;
        logic [7:0] expBus;
        logic       expValid;
        logic       expOverrun;
        logic       ackAfter;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge shiftClk);
        #1;
        if (dataValid === 1'b1 && prevValid !== 1'b1) riseCount++;
        prevValid = dataValid;
    endtask

    // One complete frame; checks busy and that dataValid holds its prior value until the last strobe.
    task automatic sendFrame(input logic [7:0] word, input int gap, input logic strobeOnStart,
                             input logic ackOnLast, input logic preValid);
        frameStart   = 1'b1;
        shiftEnabled = strobeOnStart;
        serialIn     = 1'b1;
        tick();
        frameStart   = 1'b0;
        shiftEnabled = 1'b0;
        check("busy_after_start", busy, 1);
        for (int i = 7; i >= 0; i--) begin
            for (int g = 0; g < gap; g++) begin
                tick();
                check("busy_in_gap", busy, 1);
                check("valid_in_gap", dataValid, preValid);
            end
            shiftEnabled = 1'b1;
            serialIn     = word[i];
            dataAck      = (i == 0) ? ackOnLast : 1'b0;
            tick();
            shiftEnabled = 1'b0;
            dataAck      = 1'b0;
            if (i != 0) begin
                check("busy_mid_frame", busy, 1);
                check("valid_mid_frame", dataValid, preValid);
            end
        end
        check("busy_after_last", busy, 0);
    endtask

    initial begin
        logic [7:0] tmp;
        int startRises;

        //             word   gap sOS ackL preV  expBus expV expO ackAfter
        vecs[0] = '{8'hA5, 0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h3C, 3, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h11, 0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h22, 0, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h11, 1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h22, 0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1};

        // Reset state.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_bus", dataBus, 8'h00);
        check("reset_valid", dataValid, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);

        // Strobes and ack in IDLE have no effect.
        shiftEnabled = 1'b1;
        serialIn     = 1'b1;
        dataAck      = 1'b1;
        tick();
        tick();
        tick();
        shiftEnabled = 1'b0;
        dataAck      = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_valid", dataValid, 0);
        check("idle_bus", dataBus, 8'h00);

        // Table of frames.
        for (int v = 0; v < 6; v++) begin
            sendFrame(vecs[v].word, vecs[v].gap, vecs[v].strobeOnStart, vecs[v].ackOnLast, vecs[v].preValid);
            check("vec_bus", dataBus, vecs[v].expBus);
            check("vec_valid", dataValid, vecs[v].expValid);
            check("vec_overrun", overrun, vecs[v].expOverrun);
            if (vecs[v].ackAfter) begin
                dataAck = 1'b1;
                tick();
                dataAck = 1'b0;
                check("ack_valid", dataValid, 0);
                check("ack_overrun", overrun, vecs[v].expOverrun);
                check("ack_bus_held", dataBus, vecs[v].expBus);
            end
        end

        // Abort: 4 bits of 0xF0, frameStart with a coincident strobe, then 0x0F.
        startRises = riseCount;
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            shiftEnabled = 1'b1;
            serialIn     = 1'b1;
            tick();
        end
        frameStart   = 1'b1;
        shiftEnabled = 1'b1;
        serialIn     = 1'b1;
        tick();
        frameStart = 1'b0;
        check("abort_busy", busy, 1);
        tmp = 8'h0F;
        for (int i = 7; i >= 0; i--) begin
            shiftEnabled = 1'b1;
            serialIn     = tmp[i];
            tick();
        end
        shiftEnabled = 1'b0;
        check("abort_bus", dataBus, 8'h0F);
        check("abort_rises", riseCount - startRises, 1);
        check("abort_busy_end", busy, 0);

        // Reset mid-frame with dataValid and overrun set.
        sendFrame(8'h55, 0, 1'b0, 1'b0, 1'b1);
        check("pre_reset_valid", dataValid, 1);
        check("pre_reset_overrun", overrun, 1);
        check("pre_reset_bus", dataBus, 8'h0F);
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            shiftEnabled = 1'b1;
            serialIn     = 1'b1;
            tick();
        end
        shiftEnabled = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset_bus", dataBus, 8'h00);
        check("midreset_valid", dataValid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_overrun", overrun, 0);
        sendFrame(8'h81, 0, 1'b1, 1'b0, 1'b0);
        check("post_reset_bus", dataBus, 8'h81);
        check("post_reset_valid", dataValid, 1);
        check("post_reset_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
